// File: rtl/fuser_scheduler_pkg.sv
// Shared types and defaults for the modality-to-fuser scheduler.
// Default sizes are overridden per instance through module parameters.
package fuser_scheduler_pkg;

    localparam int NUM_MODALITY_DEF = 3;
    localparam int HV_DIMENSION_DEF = 8;
    localparam int WIN_CNT_W_DEF    = 16;
    localparam int MOD_W            = $clog2(NUM_MODALITY_DEF);

    typedef logic [HV_DIMENSION_DEF-1:0] hv_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } fsched_state_e;

    // Select width that stays at least one bit wide.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fuser_scheduler_hv_onehot_mux.sv
// N:1 hypervector select in AND-OR form; also steers the single ready back
// to the granted modality. Everything is zero while en_i is low.
module hv_onehot_mux #(
    parameter int N     = 3,
    parameter int D     = 8,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    input  logic             ready_i,
    input  logic [N-1:0]     valid_i,
    input  logic [N*D-1:0]   hv_i,
    output logic             valid_o,
    output logic [D-1:0]     hv_o,
    output logic [N-1:0]     ready_o
);

    logic [N-1:0] onehot;
    logic [N-1:0] valid_terms;
    logic [D-1:0] hv_terms [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign onehot[gi]      = en_i && (sel_i == SEL_W'(gi));
            assign valid_terms[gi] = onehot[gi] & valid_i[gi];
            assign ready_o[gi]     = onehot[gi] & ready_i;
            assign hv_terms[gi]    = hv_i[gi*D +: D] & {D{onehot[gi]}};
        end
    endgenerate

    always_comb begin
        hv_o = '0;
        for (int i = 0; i < N; i++) begin
            hv_o = hv_o | hv_terms[i];
        end
    end

    assign valid_o = |valid_terms;

endmodule

// File: rtl/fuser_scheduler.sv
// Feeds one HV per modality, in order, into a single-input fuser, then waits
// for the fused result to leave before opening the next window.
module fuser_scheduler
    import fuser_scheduler_pkg::*;
#(
    parameter int NUM_MODALITY = NUM_MODALITY_DEF,
    parameter int HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int WIN_CNT_W    = WIN_CNT_W_DEF,
    localparam int SEL_W       = sel_width(NUM_MODALITY)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic [NUM_MODALITY-1:0]        mod_valid_i,
    output logic [NUM_MODALITY-1:0]        mod_ready_o,
    input  logic [NUM_MODALITY*HV_DIMENSION-1:0] mod_hv_i,
    output logic                           fz_hvin_valid_o,
    input  logic                           fz_hvin_ready_i,
    output logic [HV_DIMENSION-1:0]        fz_hvin_o,
    input  logic                           fz_hvout_valid_i,
    input  logic                           fz_hvout_ready_i,
    output logic [SEL_W-1:0]               sel_o,
    output logic                           busy_o,
    output logic [WIN_CNT_W-1:0]           win_cnt_o,
    output logic                           proto_err_o
);

    localparam int WD_W = $clog2(NUM_MODALITY + 3);
    localparam logic [WD_W-1:0]      WD_LIMIT = WD_W'(NUM_MODALITY + 2);
    localparam logic [WD_W-1:0]      WD_ONE   = WD_W'(1);
    localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(NUM_MODALITY - 1);
    localparam logic [SEL_W-1:0]     SEL_ONE  = SEL_W'(1);
    localparam logic [WIN_CNT_W-1:0] WIN_ONE  = WIN_CNT_W'(1);

    fsched_state_e        state_q;
    logic [SEL_W-1:0]     sel_q;
    logic                 busy_q;
    logic                 collect_q;
    logic [WIN_CNT_W-1:0] win_cnt_q;
    logic                 proto_err_q;
    logic [WD_W-1:0]      wd_q;

    logic fire;
    logic out_fire;

    hv_onehot_mux #(
        .N     (NUM_MODALITY),
        .D     (HV_DIMENSION),
        .SEL_W (SEL_W)
    ) u_mux (
        .sel_i   (sel_q),
        .en_i    (collect_q),
        .ready_i (fz_hvin_ready_i),
        .valid_i (mod_valid_i),
        .hv_i    (mod_hv_i),
        .valid_o (fz_hvin_valid_o),
        .hv_o    (fz_hvin_o),
        .ready_o (mod_ready_o)
    );

    // The mux valid is already gated by collect_q, so this only fires while collecting.
    assign fire     = fz_hvin_valid_o && fz_hvin_ready_i;
    assign out_fire = (state_q == S_DRAIN) && fz_hvout_valid_i && fz_hvout_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            collect_q   <= 1'b0;
            win_cnt_q   <= '0;
            proto_err_q <= 1'b0;
            wd_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en_i) begin
                        state_q   <= S_COLLECT;
                        sel_q     <= '0;
                        busy_q    <= 1'b1;
                        collect_q <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (fire) begin
                        if (sel_q == SEL_LAST) begin
                            sel_q     <= '0;
                            state_q   <= S_DRAIN;
                            collect_q <= 1'b0;
                        end else begin
                            sel_q <= sel_q + SEL_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        win_cnt_q <= win_cnt_q + WIN_ONE;
                        sel_q     <= '0;
                        if (en_i) begin
                            state_q   <= S_COLLECT;
                            collect_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    sel_q     <= '0;
                    busy_q    <= 1'b0;
                    collect_q <= 1'b0;
                end
            endcase

            // A fuser still asking for input while draining never saw the full window.
            if ((state_q == S_DRAIN) && fz_hvin_ready_i) begin
                if (wd_q == WD_LIMIT) begin
                    proto_err_q <= 1'b1;
                end else begin
                    wd_q <= wd_q + WD_ONE;
                end
            end else begin
                wd_q <= '0;
            end

            if (fz_hvout_valid_i && (state_q != S_DRAIN)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign sel_o       = sel_q;
    assign busy_o      = busy_q;
    assign win_cnt_o   = win_cnt_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_fuser_scheduler.sv
// Directed bench for fuser_scheduler (N=3, D=8) driving a small majority-fuser model.
module tb_fuser_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  mod_valid;
    logic [2:0]  mod_ready;
    logic [23:0] mod_hv;
    logic        fz_hvin_valid;
    logic        fz_hvin_ready;
    logic [7:0]  fz_hvin;
    logic        fz_hvout_valid;
    logic        fz_hvout_ready;
    logic [1:0]  sel;
    logic        busy;
    logic [15:0] win_cnt;
    logic        proto_err;

    logic [2:0]  s_mod_ready;
    logic        s_fz_hvin_valid;
    logic [7:0]  s_fz_hvin;
    logic [1:0]  s_sel;
    logic        s_busy;
    logic [1:0]  s_win_cnt;
    logic        s_proto_err;

    // fuser model state and overrides
    logic [1:0]  fz_cnt;
    logic [7:0]  fz_buf [3];
    logic [7:0]  fused_last;
    logic        force_ready;
    logic        force_ovalid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fuser_scheduler #(.NUM_MODALITY(3), .HV_DIMENSION(8), .WIN_CNT_W(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .en_i             (en),
        .mod_valid_i      (mod_valid),
        .mod_ready_o      (mod_ready),
        .mod_hv_i         (mod_hv),
        .fz_hvin_valid_o  (fz_hvin_valid),
        .fz_hvin_ready_i  (fz_hvin_ready),
        .fz_hvin_o        (fz_hvin),
        .fz_hvout_valid_i (fz_hvout_valid),
        .fz_hvout_ready_i (fz_hvout_ready),
        .sel_o            (sel),
        .busy_o           (busy),
        .win_cnt_o        (win_cnt),
        .proto_err_o      (proto_err)
    );

    // Narrow-counter twin on the same inputs to observe the wrap quickly.
    fuser_scheduler #(.NUM_MODALITY(3), .HV_DIMENSION(8), .WIN_CNT_W(2)) dut_small (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .en_i             (en),
        .mod_valid_i      (mod_valid),
        .mod_ready_o      (s_mod_ready),
        .mod_hv_i         (mod_hv),
        .fz_hvin_valid_o  (s_fz_hvin_valid),
        .fz_hvin_ready_i  (fz_hvin_ready),
        .fz_hvin_o        (s_fz_hvin),
        .fz_hvout_valid_i (fz_hvout_valid),
        .fz_hvout_ready_i (fz_hvout_ready),
        .sel_o            (s_sel),
        .busy_o           (s_busy),
        .win_cnt_o        (s_win_cnt),
        .proto_err_o      (s_proto_err)
    );

    function automatic logic [7:0] maj3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign fz_hvin_ready  = force_ready || (fz_cnt != 2'd3);
    assign fz_hvout_valid = force_ovalid || (fz_cnt == 2'd3);

    always @(posedge clk) begin
        if (!rst_n) begin
            fz_cnt     <= 2'd0;
            fused_last <= 8'h00;
        end else if (fz_hvin_valid && fz_hvin_ready && (fz_cnt != 2'd3)) begin
            fz_buf[fz_cnt] <= fz_hvin;
            fz_cnt         <= fz_cnt + 2'd1;
        end else if ((fz_cnt == 2'd3) && fz_hvout_ready) begin
            fz_cnt     <= 2'd0;
            fused_last <= maj3(fz_buf[0], fz_buf[1], fz_buf[2]);
        end
    end

    typedef struct {
        logic        en;
        logic [2:0]  mv;
        logic        oready;
        logic [2:0]  ex_mr;
        logic        ex_fv;
        logic [7:0]  ex_hv;
        logic [1:0]  ex_sel;
        logic        ex_busy;
        logic [15:0] ex_win;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic [2:0] mv, input logic orr,
                       input logic [2:0] mr, input logic fv, input logic [7:0] hv,
                       input logic [1:0] s, input logic b, input logic [15:0] w);
        vec_t v;
        v.en = e; v.mv = mv; v.oready = orr; v.ex_mr = mr; v.ex_fv = fv;
        v.ex_hv = hv; v.ex_sel = s; v.ex_busy = b; v.ex_win = w;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_win(input logic [15:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (win_cnt == target) break;
            tick();
        end
        check("wait_win", {16'h0, win_cnt}, {16'h0, target});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mod_valid = 3'b000; mod_hv = {8'hF0, 8'hCC, 8'hAA};
        fz_hvout_ready = 1'b1; force_ready = 1'b0; force_ovalid = 1'b0;

        // 1: reset
        tick(); tick();
        check("rst mod_ready", {29'h0, mod_ready}, 32'h0);
        check("rst sel", {30'h0, sel}, 32'h0);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst win_cnt", {16'h0, win_cnt}, 32'h0);
        check("rst proto_err", {31'h0, proto_err}, 32'h0);
        rst_n = 1'b1;

        // 2: full window; 3: modality 1 stalls; 4: drain back-pressure; 5: en drop
        add(1, 3'b111, 1, 3'b000, 0, 8'h00, 0, 0, 0);
        add(1, 3'b111, 1, 3'b001, 1, 8'hAA, 0, 1, 0);
        add(1, 3'b111, 1, 3'b010, 1, 8'hCC, 1, 1, 0);
        add(1, 3'b111, 1, 3'b100, 1, 8'hF0, 2, 1, 0);
        add(1, 3'b111, 1, 3'b000, 0, 8'h00, 0, 1, 0);
        add(1, 3'b111, 1, 3'b001, 1, 8'hAA, 0, 1, 1);
        for (int k = 0; k < 5; k++) add(1, 3'b101, 1, 3'b010, 0, 8'hCC, 1, 1, 1);
        add(1, 3'b111, 1, 3'b010, 1, 8'hCC, 1, 1, 1);
        add(1, 3'b111, 1, 3'b100, 1, 8'hF0, 2, 1, 1);
        for (int k = 0; k < 4; k++) add(1, 3'b111, 0, 3'b000, 0, 8'h00, 0, 1, 1);
        add(1, 3'b111, 1, 3'b000, 0, 8'h00, 0, 1, 1);
        add(1, 3'b111, 1, 3'b001, 1, 8'hAA, 0, 1, 2);
        add(0, 3'b111, 1, 3'b010, 1, 8'hCC, 1, 1, 2);
        add(0, 3'b111, 1, 3'b100, 1, 8'hF0, 2, 1, 2);
        add(0, 3'b111, 1, 3'b000, 0, 8'h00, 0, 1, 2);
        add(0, 3'b111, 1, 3'b000, 0, 8'h00, 0, 0, 3);
        add(0, 3'b111, 1, 3'b000, 0, 8'h00, 0, 0, 3);
        add(1, 3'b111, 1, 3'b000, 0, 8'h00, 0, 0, 3);
        add(1, 3'b111, 1, 3'b001, 1, 8'hAA, 0, 1, 3);

        foreach (vecs[i]) begin
            en = vecs[i].en; mod_valid = vecs[i].mv; fz_hvout_ready = vecs[i].oready;
            #1;
            check($sformatf("v%0d mod_ready", i), {29'h0, mod_ready}, {29'h0, vecs[i].ex_mr});
            check($sformatf("v%0d hvin_valid", i), {31'h0, fz_hvin_valid}, {31'h0, vecs[i].ex_fv});
            check($sformatf("v%0d hvin", i), {24'h0, fz_hvin}, {24'h0, vecs[i].ex_hv});
            check($sformatf("v%0d sel", i), {30'h0, sel}, {30'h0, vecs[i].ex_sel});
            check($sformatf("v%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].ex_busy});
            check($sformatf("v%0d win_cnt", i), {16'h0, win_cnt}, {16'h0, vecs[i].ex_win});
            check($sformatf("v%0d small win_cnt", i), {30'h0, s_win_cnt}, {30'h0, vecs[i].ex_win[1:0]});
            check($sformatf("v%0d proto_err", i), {31'h0, proto_err}, 32'h0);
            tick();
        end
        check("fused AA/CC/F0", {24'h0, fused_last}, 32'hE8);

        // 6: reset while sel==2, then a clean window with new data
        en = 1'b1; mod_valid = 3'b111; fz_hvout_ready = 1'b1;
        tick();
        check("pre-reset sel", {30'h0, sel}, 32'h2);
        rst_n = 1'b0;
        tick();
        check("mid rst sel", {30'h0, sel}, 32'h0);
        check("mid rst busy", {31'h0, busy}, 32'h0);
        check("mid rst mod_ready", {29'h0, mod_ready}, 32'h0);
        check("mid rst win_cnt", {16'h0, win_cnt}, 32'h0);
        rst_n = 1'b1;
        mod_hv = {8'h0F, 8'h33, 8'h55};
        wait_win(16'd1, 20);
        check("fused 55/33/0F", {24'h0, fused_last}, 32'h17);
        wait_win(16'd3, 40);
        check("small win_cnt 3", {30'h0, s_win_cnt}, 32'h3);
        wait_win(16'd4, 20);
        check("small win_cnt wrap", {30'h0, s_win_cnt}, 32'h0);

        // hvout_valid outside drain is a protocol error, and it sticks
        rst_n = 1'b0; en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("idle proto_err clear", {31'h0, proto_err}, 32'h0);
        force_ovalid = 1'b1;
        tick();
        force_ovalid = 1'b0;
        check("idle hvout proto_err", {31'h0, proto_err}, 32'h1);
        tick();
        check("proto_err sticky", {31'h0, proto_err}, 32'h1);

        // watchdog: fuser keeps requesting input through the drain
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b1; mod_valid = 3'b111; fz_hvout_ready = 1'b0;
        tick(); tick(); tick(); tick();
        check("wd drain busy", {31'h0, busy}, 32'h1);
        check("wd drain mod_ready", {29'h0, mod_ready}, 32'h0);
        force_ready = 1'b1; en = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("wd N+2 cycles", {31'h0, proto_err}, 32'h0);
        tick();
        check("wd N+3 cycles", {31'h0, proto_err}, 32'h1);
        force_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
